// File: rtl/mcyc_pkg.sv
// mcyc_pkg: shared types and constants for the multi-cycle control unit.
//   state_t   - FSM state encoding
//   OP_*      - supported major opcodes
//   ALU_*     - alu_op encodings driven to the datapath
//   DT_*      - memory access size encodings
//   dec_t     - decoded control bundle produced by mcyc_decode
package mcyc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] DT_BYTE = 2'b10;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b00;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       opa_sel;     // 1 = PC
    logic       opb_sel;     // 1 = immediate
    logic [1:0] data_type;
    logic       is_unsigned;
    logic       br_un;
    logic       is_alu;      // R / I / LUI
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       legal;
  } dec_t;

  // funct3[1:0] of a load/store -> access size
  function automatic logic [1:0] f3_to_dt(input logic [1:0] f3);
    case (f3)
      2'b00:   return DT_BYTE;
      2'b01:   return DT_HALF;
      default: return DT_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mcyc_decode.sv
// mcyc_decode: purely combinational instruction decode.
//   ir  - instruction register contents
//   dec - alu_op, operand selects, access size/sign, class flags, legal
module mcyc_decode
  import mcyc_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [2:0] f3;
  assign f3 = ir[14:12];

  // alt selects SUB/SRA; callers mask it so ADDI can never become SUB
  function automatic logic [3:0] alu_fn(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec = '0;
    case (ir[6:0])
      OP_R: begin
        dec.legal  = 1'b1;
        dec.is_alu = 1'b1;
        dec.alu_op = alu_fn(f3, ir[30]);
      end
      OP_I: begin
        dec.legal   = 1'b1;
        dec.is_alu  = 1'b1;
        dec.opb_sel = 1'b1;
        dec.alu_op  = alu_fn(f3, ir[30] & (f3 == 3'b101));
      end
      OP_LUI: begin
        dec.legal   = 1'b1;
        dec.is_alu  = 1'b1;
        dec.opb_sel = 1'b1;
        dec.alu_op  = ALU_LUI;
      end
      OP_LOAD: begin
        dec.legal       = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.is_load     = 1'b1;
        dec.opb_sel     = 1'b1;
        dec.data_type   = f3_to_dt(f3[1:0]);
        dec.is_unsigned = f3[2];
      end
      OP_STORE: begin
        dec.legal     = f3 inside {3'b000, 3'b001, 3'b010};
        dec.is_store  = 1'b1;
        dec.opb_sel   = 1'b1;
        dec.data_type = f3_to_dt(f3[1:0]);
      end
      OP_BRANCH: begin
        // target = PC + imm; the compare itself is done by the comparator
        dec.legal     = 1'b1;
        dec.is_branch = 1'b1;
        dec.opa_sel   = 1'b1;
        dec.opb_sel   = 1'b1;
        dec.br_un     = f3[1];
      end
      default: dec.legal = 1'b0;
    endcase
  end

  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

endmodule

// File: rtl/mcyc_ctrl_unit.sv
// mcyc_ctrl_unit: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//   i_clk, i_rst_n            - clock, async active-low reset
//   i_instr, i_mem_ack        - fetched word and memory handshake
//   i_br_less, i_br_equal     - comparator results (used in EXEC)
//   o_mem_req, o_mem_wren     - memory request / store qualifier
//   o_ir_wren, o_pc_wren, o_pc_sel, o_rd_wren, o_opa_sel, o_opb_sel,
//   o_br_un, o_alu_op, o_wb_sel, o_data_type, o_unsigned - datapath controls
//   o_insn_vld                - one-cycle retire pulse
//   o_illegal                 - high while in TRAP (sticky until reset)
//   o_timeout                 - only with MCYC_TIMEOUT_EN: ack wait expired
// Optional build macro: MCYC_TIMEOUT_EN (bounded memory-ack wait).
module mcyc_ctrl_unit
  import mcyc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic        o_ir_wren,
  output logic        o_pc_wren,
  output logic        o_pc_sel,
  output logic        o_rd_wren,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic        o_br_un,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_wb_sel,
  output logic [1:0]  o_data_type,
  output logic        o_unsigned,
  output logic        o_insn_vld,
  output logic        o_illegal
`ifdef MCYC_TIMEOUT_EN
  ,
  output logic        o_timeout
`endif
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic        run_q;   // holds o_mem_req low until the first clock after reset
  dec_t        dec;
  logic        req_act, ack_ok, taken, to_hit;

  mcyc_decode u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  assign req_act = run_q && (state_q == ST_FETCH || state_q == ST_MEM);
  assign ack_ok  = req_act && i_mem_ack;

  always_comb begin
    case (ir_q[14:12])
      3'b000:         taken = i_br_equal;
      3'b001:         taken = !i_br_equal;
      3'b100, 3'b110: taken = i_br_less;
      3'b101, 3'b111: taken = !i_br_less;
      default:        taken = 1'b0;
    endcase
  end

`ifdef MCYC_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       timeout_q;

  assign to_hit    = req_act && !i_mem_ack && (wait_q == TO_LIM);
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (ack_ok || state_d != state_q) wait_q <= '0;
      else if (req_act)                 wait_q <= wait_q + 8'd1;
      if (to_hit) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign to_hit     = 1'b0;
  assign unused_cfg = ^TO_LIM;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= IR_NOP;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == ST_FETCH && ack_ok) ir_q <= i_instr;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_mem_req   = 1'b0;
    o_mem_wren  = 1'b0;
    o_ir_wren   = 1'b0;
    o_pc_wren   = 1'b0;
    o_pc_sel    = 1'b0;
    o_rd_wren   = 1'b0;
    o_opa_sel   = 1'b0;
    o_opb_sel   = 1'b0;
    o_br_un     = 1'b0;
    o_alu_op    = ALU_ADD;
    o_wb_sel    = 2'b00;
    o_data_type = DT_WORD;
    o_unsigned  = 1'b0;
    o_insn_vld  = 1'b0;
    o_illegal   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        o_mem_req = run_q;
        o_ir_wren = ack_ok;
        if (ack_ok)      state_d = ST_DECODE;
        else if (to_hit) state_d = ST_TRAP;
      end
      ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (dec.is_branch) begin
          o_br_un    = dec.br_un;
          o_pc_wren  = 1'b1;
          o_pc_sel   = taken;
          o_insn_vld = 1'b1;
          state_d    = ST_FETCH;
        end else if (dec.is_load || dec.is_store) state_d = ST_MEM;
        else if (dec.is_alu)                      state_d = ST_WB;
        else                                      state_d = ST_TRAP;
      end
      ST_MEM: begin
        o_mem_req  = 1'b1;
        o_mem_wren = dec.is_store;
        if (ack_ok) begin
          if (dec.is_store) begin
            o_pc_wren  = 1'b1;
            o_insn_vld = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (to_hit) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        o_rd_wren  = (ir_q[11:7] != 5'd0);
        o_wb_sel   = dec.is_load ? WB_MEM : WB_ALU;
        o_pc_wren  = 1'b1;
        o_insn_vld = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP:  o_illegal = 1'b1;
      default:  state_d = ST_FETCH;
    endcase

    // ALU operands and access size stay up through MEM and WB so the
    // combinational address / result path is stable for the whole access.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      o_alu_op    = dec.alu_op;
      o_opa_sel   = dec.opa_sel;
      o_opb_sel   = dec.opb_sel;
      o_data_type = dec.data_type;
      o_unsigned  = dec.is_unsigned;
    end
  end

endmodule

// File: tb/tb_mcyc_ctrl_unit.sv
// tb_mcyc_ctrl_unit: directed stimulus with a retire scoreboard.
module tb_mcyc_ctrl_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_instr;
  logic        i_br_less, i_br_equal, i_mem_ack;
  logic        o_mem_req, o_mem_wren, o_ir_wren, o_pc_wren, o_pc_sel;
  logic        o_rd_wren, o_opa_sel, o_opb_sel, o_br_un, o_unsigned;
  logic        o_insn_vld, o_illegal;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_wb_sel, o_data_type;
`ifdef MCYC_TIMEOUT_EN
  logic        o_timeout;
`endif

  always #5 i_clk = ~i_clk;

  mcyc_ctrl_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal), .i_mem_ack(i_mem_ack),
    .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_ir_wren(o_ir_wren),
    .o_pc_wren(o_pc_wren), .o_pc_sel(o_pc_sel), .o_rd_wren(o_rd_wren),
    .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_br_un(o_br_un),
    .o_alu_op(o_alu_op), .o_wb_sel(o_wb_sel), .o_data_type(o_data_type),
    .o_unsigned(o_unsigned), .o_insn_vld(o_insn_vld), .o_illegal(o_illegal)
`ifdef MCYC_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  typedef struct {
    string      nm;
    int         lat;
    int         req;
    logic [3:0] alu;
    logic       pc_sel, rd_wren;
    logic [1:0] wb, dt;
    logic       uns, br_un, mem_wren;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(string nm, int lat, int req, logic [3:0] alu,
                              logic ps, logic rw, logic [1:0] wb, logic [1:0] dt,
                              logic uns, logic bu, logic mw);
    exp_t e;
    e.nm = nm; e.lat = lat; e.req = req; e.alu = alu; e.pc_sel = ps;
    e.rd_wren = rw; e.wb = wb; e.dt = dt; e.uns = uns; e.br_un = bu;
    e.mem_wren = mw;
    return e;
  endfunction

  function automatic logic [18:0] all_outs();
    return {o_mem_req, o_mem_wren, o_ir_wren, o_pc_wren, o_pc_sel, o_rd_wren,
            o_opa_sel, o_opb_sel, o_br_un, o_alu_op, o_wb_sel, o_data_type,
            o_unsigned, o_insn_vld, o_illegal};
  endfunction

  // monitor: counts cycles and request cycles per instruction, checks at retire
  initial begin : monitor
    int   lat_c, req_c;
    bit   started;
    exp_t e;
    lat_c = 0; req_c = 0; started = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        started = 0; lat_c = 0; req_c = 0;
      end else begin
        if (o_mem_req) started = 1;
        if (started) lat_c++;
        if (o_mem_req) req_c++;
        if (o_insn_vld) begin
          if (sb.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk({e.nm, "_latency"},  lat_c,       e.lat);
            chk({e.nm, "_req_cyc"},  req_c,       e.req);
            chk({e.nm, "_alu_op"},   o_alu_op,    e.alu);
            chk({e.nm, "_pc_wren"},  o_pc_wren,   1);
            chk({e.nm, "_pc_sel"},   o_pc_sel,    e.pc_sel);
            chk({e.nm, "_rd_wren"},  o_rd_wren,   e.rd_wren);
            chk({e.nm, "_wb_sel"},   o_wb_sel,    e.wb);
            chk({e.nm, "_dtype"},    o_data_type, e.dt);
            chk({e.nm, "_unsigned"}, o_unsigned,  e.uns);
            chk({e.nm, "_br_un"},    o_br_un,     e.br_un);
            chk({e.nm, "_mem_wren"}, o_mem_wren,  e.mem_wren);
          end
          lat_c = 0; req_c = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_req(string nm);
    for (int k = 0; k < 20 && o_mem_req !== 1'b1; k++) step();
    chk({nm, "_wait_req"}, o_mem_req, 1);
  endtask

  // md < 0: no memory phase
  task automatic issue(logic [31:0] w, int fd, int md, logic less, logic eq, exp_t e);
    wait_req(e.nm);
    i_br_less = less; i_br_equal = eq;
    sb.push_back(e);
    repeat (fd) step();
    i_mem_ack = 1'b1; i_instr = w;
    #1 chk({e.nm, "_ir_wren"}, o_ir_wren, 1);
    step();
    i_mem_ack = 1'b0; i_instr = 32'hFFFF_FFFF;  // IR must have latched the word
    if (md >= 0) begin
      step(); step();
      chk({e.nm, "_mem_req_in_mem"}, o_mem_req, 1);
      chk({e.nm, "_dtype_in_mem"},   o_data_type, e.dt);
      repeat (md) step();
      i_mem_ack = 1'b1;
      step();
      i_mem_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_mem_ack = 1'b0;
    repeat (2) step();
    i_rst_n = 1'b1;
  endtask

  task automatic do_trap(string nm, logic [31:0] w);
    bit bad;
    wait_req(nm);
    i_mem_ack = 1'b1; i_instr = w;
    step();
    i_mem_ack = 1'b0;
    chk({nm, "_decode_not_illegal"}, o_illegal, 0);
    step();
    chk({nm, "_illegal"}, o_illegal, 1);
    chk({nm, "_mem_req"}, o_mem_req, 0);
    bad = 0;
    repeat (8) begin
      i_mem_ack = 1'b1;
      step();
      bad |= o_mem_req | o_mem_wren | o_ir_wren | o_pc_wren | o_rd_wren |
             o_insn_vld | !o_illegal;
    end
    i_mem_ack = 1'b0;
    chk({nm, "_trap_quiet"}, bad, 0);
    do_reset();
  endtask

  initial begin : driver
    i_rst_n = 1'b0; i_instr = 32'h0; i_br_less = 1'b0; i_br_equal = 1'b0;
    i_mem_ack = 1'b1;
    repeat (3) step();
    chk("reset_outputs", all_outs(), 0);
    i_mem_ack = 1'b0;
    i_rst_n = 1'b1;
    #1 chk("req_before_first_clk", o_mem_req, 0);
    step();
    chk("req_after_first_clk", o_mem_req, 1);

    //          word          fd md  lt eq      name    lat req alu    ps rw wb     dt     un bu mw
    issue(32'h002081B3, 0, -1, 0, 0, mk("ADD",   4, 1, 4'b0000, 0, 1, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h402081B3, 1, -1, 0, 0, mk("SUB",   5, 2, 4'b0001, 0, 1, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h0020B1B3, 0, -1, 0, 0, mk("SLTU",  4, 1, 4'b0011, 0, 1, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h0000C283, 0,  3, 0, 0, mk("LBU",   8, 5, 4'b0000, 0, 1, 2'b00, 2'b10, 1, 0, 0));
    issue(32'h00209303, 2,  1, 0, 0, mk("LH",    8, 5, 4'b0000, 0, 1, 2'b00, 2'b01, 0, 0, 0));
    issue(32'h0020A223, 0,  0, 0, 0, mk("SW",    4, 2, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    issue(32'h00209463, 0, -1, 0, 0, mk("BNE_T", 3, 1, 4'b0000, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    issue(32'h00209463, 0, -1, 0, 1, mk("BNE_N", 3, 1, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    issue(32'h0020E463, 0, -1, 1, 0, mk("BLTU",  3, 1, 4'b0000, 1, 0, 2'b00, 2'b00, 0, 1, 0));
    issue(32'h0020D463, 0, -1, 1, 0, mk("BGE",   3, 1, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    issue(32'h00208463, 2, -1, 0, 1, mk("BEQ",   5, 3, 4'b0000, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    issue(32'h00500013, 0, -1, 0, 0, mk("ADDI0", 4, 1, 4'b0000, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h4030D213, 0, -1, 0, 0, mk("SRAI",  4, 1, 4'b1001, 0, 1, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h40008093, 0, -1, 0, 0, mk("ADDI30",4, 1, 4'b0000, 0, 1, 2'b01, 2'b00, 0, 0, 0));
    issue(32'h123453B7, 0, -1, 0, 0, mk("LUI",   4, 1, 4'b1111, 0, 1, 2'b01, 2'b00, 0, 0, 0));

    // reset during a waiting store: access aborted, no retire
    wait_req("ABORT");
    i_mem_ack = 1'b1; i_instr = 32'h0020A223;
    step();
    i_mem_ack = 1'b0;
    step(); step();
    chk("abort_in_mem", o_mem_wren, 1);
    step();
    i_rst_n = 1'b0;
    #1 chk("abort_outputs", all_outs(), 0);
    step(); step();
    i_rst_n = 1'b1;
    #1 chk("abort_req_low", o_mem_req, 0);
    step();
    chk("abort_req_back", o_mem_req, 1);
    issue(32'h002081B3, 0, -1, 0, 0, mk("ADD2",  4, 1, 4'b0000, 0, 1, 2'b01, 2'b00, 0, 0, 0));

    do_trap("ILL_FF", 32'hFFFF_FFFF);
    do_trap("ILL_LD", 32'h0000_3003);
    do_trap("ILL_SD", 32'h0000_3023);
    issue(32'h0000C283, 1,  0, 0, 0, mk("LBU2",  6, 3, 4'b0000, 0, 1, 2'b00, 2'b10, 1, 0, 0));

`ifdef MCYC_TIMEOUT_EN
    do_reset();
    repeat (4) step();
    chk("to_still_fetch", o_mem_req, 1);
    chk("to_not_yet", o_timeout, 0);
    step();
    chk("to_timeout", o_timeout, 1);
    chk("to_illegal", o_illegal, 1);
    chk("to_req_low", o_mem_req, 0);
`endif

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
